// File: rtl/inbuf_pkg.sv
// rtl/inbuf_pkg.sv - shared constants and types for the PE-array input buffer
//
// Purpose: geometry of the double-buffered input buffer, loader state
// encoding and the MLP row-length legality check. Shared by the loader,
// the buffer and the consumer sequencer.
// Ports: none (package).
package inbuf_pkg;

  localparam int N_ROWS     = 7;    // MLP rows per bank
  localparam int K_MAX      = 384;  // bytes per MLP row
  localparam int N_PE       = 12;   // PEs per conv bank
  localparam int N_WIN      = 7;    // windows per PE
  localparam int N_TAP      = 4;    // bytes per 32-bit word

  localparam int CONV_WORDS = N_PE * N_WIN;
  localparam int MLP_KW_MAX = K_MAX / N_TAP;

  // Widths of the two address counters; the inner one must hold a k_word
  // index up to MLP_KW_MAX-1, the outer one a PE index up to N_PE-1.
  localparam int INNER_W    = 7;
  localparam int OUTER_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_SWAP_WAIT
  } loader_state_t;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_MLP  = 1'b1
  } load_mode_t;

  function automatic logic kw_legal(input logic [INNER_W-1:0] kw);
    return (kw != '0) && (int'(kw) <= MLP_KW_MAX);
  endfunction

endpackage

// File: rtl/input_buf_loader_if.sv
// rtl/input_buf_loader_if.sv - word stream and shadow-bank write bus of the loader
//
// Purpose: bundles the inbound 32-bit word stream and the two write ports
// (conv and MLP layout) of the shadow bank.
// Ports:
//   s_valid/s_data/s_ready         inbound word stream
//   conv_load_en/pe_idx/win_idx/data  conv layout write port
//   mlp_load_en/row/k_word/data       MLP layout write port
// Modports: slave = loader side, master = stream source / bank side.
interface input_buf_loader_if;
  import inbuf_pkg::*;

  logic                s_valid;
  logic [31:0]         s_data;
  logic                s_ready;

  logic                conv_load_en;
  logic [3:0]          conv_load_pe_idx;
  logic [2:0]          conv_load_win_idx;
  logic [31:0]         conv_load_data;

  logic                mlp_load_en;
  logic [2:0]          mlp_load_row;
  logic [INNER_W-1:0]  mlp_load_k_word;
  logic [31:0]         mlp_load_data;

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output conv_load_en, conv_load_pe_idx, conv_load_win_idx, conv_load_data,
    output mlp_load_en, mlp_load_row, mlp_load_k_word, mlp_load_data
  );

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  conv_load_en, conv_load_pe_idx, conv_load_win_idx, conv_load_data,
    input  mlp_load_en, mlp_load_row, mlp_load_k_word, mlp_load_data
  );

endinterface

// File: rtl/inbuf_addr_gen.sv
// rtl/inbuf_addr_gen.sv - two-level inner/outer wrap counter for bank addressing
//
// Purpose: walks inner 0..inner_max for each outer 0..outer_max.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               restart at inner=0/outer=0
//   inc                 advance one position
//   inner_max/outer_max last index of each level (count-1)
//   inner/outer         current position
//   last                current position is the final one
module inbuf_addr_gen
  import inbuf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  input  logic [INNER_W-1:0] inner_max,
  input  logic [OUTER_W-1:0] outer_max,
  output logic [INNER_W-1:0] inner,
  output logic [OUTER_W-1:0] outer,
  output logic               last
);

  logic inner_wrap;
  logic outer_wrap;

  assign inner_wrap = (inner == inner_max);
  assign outer_wrap = (outer == outer_max);
  assign last       = inner_wrap && outer_wrap;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      inner <= '0;
      outer <= '0;
    end else if (inc) begin
      if (inner_wrap) begin
        inner <= '0;
        outer <= outer_wrap ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_buf_loader.sv
// rtl/input_buf_loader.sv - write-side sequencer for the double-buffered input buffer
//
// Purpose: fills the shadow bank from a 32-bit word stream in conv
// (pe outer / win inner) or MLP (row outer / k_word inner) layout, then
// issues a one-cycle bank swap once the consumer has released the active bank.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, cfg_mode, cfg_k_words  fill request and config, sampled in IDLE
//   cons_done                consumer released the active bank (pulse)
//   bus (slave)              word stream in, conv/MLP write ports out
//   swap, fill_done          bank swap pulse (coincident)
//   busy                     high outside IDLE
//   cfg_err                  pulse, one cycle after an illegal MLP start
module input_buf_loader
  import inbuf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cfg_mode,
  input  logic [INNER_W-1:0]  cfg_k_words,
  input  logic                cons_done,
  input_buf_loader_if.slave   bus,
  output logic                swap,
  output logic                fill_done,
  output logic                busy,
  output logic                cfg_err
);

  loader_state_t       state_q, state_d;
  load_mode_t          mode_q;
  logic [INNER_W-1:0]  kw_q;
  logic                credit_q;

  logic                accept;
  logic                cfg_bad;
  logic                xfer;
  logic                swap_c;
  logic                s_ready_c;

  logic [INNER_W-1:0]  inner;
  logic [OUTER_W-1:0]  outer;
  logic                last;
  logic [INNER_W-1:0]  inner_max;
  logic [OUTER_W-1:0]  outer_max;

  assign inner_max = (mode_q == MODE_MLP) ? kw_q - 1'b1 : INNER_W'(N_WIN - 1);
  assign outer_max = (mode_q == MODE_MLP) ? OUTER_W'(N_ROWS - 1) : OUTER_W'(N_PE - 1);

  inbuf_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .inc       (xfer),
    .inner_max (inner_max),
    .outer_max (outer_max),
    .inner     (inner),
    .outer     (outer),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // DRAIN always steps to SWAP_WAIT; with credit already present the swap
  // fires on that first SWAP_WAIT cycle, which keeps busy high through the
  // swap and gives the fixed strobe -> swap -> idle sequence.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cfg_bad   = 1'b0;
    xfer      = 1'b0;
    swap_c    = 1'b0;
    s_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_mode == MODE_CONV || kw_legal(cfg_k_words)) begin
            accept  = 1'b1;
            state_d = ST_FILL;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      ST_FILL: begin
        s_ready_c = 1'b1;
        xfer      = bus.s_valid;
        if (xfer && last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_SWAP_WAIT;
      end
      ST_SWAP_WAIT: begin
        if (credit_q) begin
          swap_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_CONV;
      kw_q   <= '0;
    end else if (accept) begin
      mode_q <= load_mode_t'(cfg_mode);
      kw_q   <= cfg_k_words;
    end
  end

  // The empty active bank after reset needs no release. A cons_done landing
  // in the swap cycle is dropped: it cannot refer to the bank just swapped in.
  always_ff @(posedge clk) begin
    if (rst)            credit_q <= 1'b1;
    else if (swap_c)    credit_q <= 1'b0;
    else if (cons_done) credit_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.conv_load_en      <= 1'b0;
      bus.conv_load_pe_idx  <= '0;
      bus.conv_load_win_idx <= '0;
      bus.conv_load_data    <= '0;
      bus.mlp_load_en       <= 1'b0;
      bus.mlp_load_row      <= '0;
      bus.mlp_load_k_word   <= '0;
      bus.mlp_load_data     <= '0;
    end else begin
      bus.conv_load_en <= xfer && (mode_q == MODE_CONV);
      bus.mlp_load_en  <= xfer && (mode_q == MODE_MLP);
      if (xfer) begin
        bus.conv_load_pe_idx  <= outer;
        bus.conv_load_win_idx <= inner[2:0];
        bus.conv_load_data    <= bus.s_data;
        bus.mlp_load_row      <= outer[2:0];
        bus.mlp_load_k_word   <= inner;
        bus.mlp_load_data     <= bus.s_data;
      end
    end
  end

  assign bus.s_ready = s_ready_c;
  assign swap        = swap_c;
  assign fill_done   = swap_c;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_input_buf_loader.sv
// tb/tb_input_buf_loader.sv - self-checking bench for input_buf_loader
module tb_input_buf_loader;
  import inbuf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cfg_mode;
  logic [6:0]  cfg_k_words;
  logic        cons_done;
  logic        swap;
  logic        fill_done;
  logic        busy;
  logic        cfg_err;

  input_buf_loader_if bus();

  input_buf_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_mode    (cfg_mode),
    .cfg_k_words (cfg_k_words),
    .cons_done   (cons_done),
    .bus         (bus),
    .swap        (swap),
    .fill_done   (fill_done),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    int          a;
    int          b;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    bit mode;
    int kw;
    int pct;
    int cons_at;
    bit exp_err;
    int exp_words;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  bit tb_credit;
  bit swap_ok;
  int glitch_chk;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Strobe scoreboard and always-on invariants.
  always @(negedge clk) begin
    if (bus.conv_load_en || bus.mlp_load_en) begin
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_strobe", 1, 0);
      end else begin
        int act_a, act_b;
        logic [31:0] act_d;
        bit ok;
        mon_e = sb_q.pop_front();
        act_a = mon_e.mode ? int'(bus.mlp_load_row)    : int'(bus.conv_load_pe_idx);
        act_b = mon_e.mode ? int'(bus.mlp_load_k_word) : int'(bus.conv_load_win_idx);
        act_d = mon_e.mode ? bus.mlp_load_data         : bus.conv_load_data;
        ok = (bus.mlp_load_en == mon_e.mode) && (bus.conv_load_en == !mon_e.mode) &&
             (act_a == mon_e.a) && (act_b == mon_e.b) && (act_d == mon_e.d);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL strobe: got conv_en=%0d mlp_en=%0d idx=%0d/%0d data=%h, required mode=%0d idx=%0d/%0d data=%h",
                   bus.conv_load_en, bus.mlp_load_en, act_a, act_b, act_d,
                   mon_e.mode, mon_e.a, mon_e.b, mon_e.d);
        end
      end
    end
    if (swap) check(swap_ok && !bus.conv_load_en && !bus.mlp_load_en, "swap_legal", swap, swap_ok);
    if (cons_done) check(!swap, "cons_done_not_in_swap", swap, 0);
    if (glitch_chk > 0) begin
      check(!cfg_err && busy, "start_in_fill_ignored", {cfg_err, busy}, 1);
      glitch_chk--;
    end
  end

  task automatic stream(input bit mode, input int kw, input int stop_at, input int pct,
                        input int cons_at, input int glitch_at);
    int n = 0;
    int cyc = 0;
    int budget = stop_at * 40 + 200;
    bit glitched = 1'b0;
    exp_t e;
    while (n < stop_at && cyc < budget) begin
      bus.s_valid = (pct >= 100) || ($urandom_range(0, 99) < pct);
      bus.s_data  = {8'($urandom_range(0, 255)), 24'(n)};
      if (cons_at >= 0 && (n == cons_at || n == cons_at + 2)) begin
        cons_done = 1'b1;
        tb_credit = 1'b1;
      end
      if (glitch_at >= 0 && n == glitch_at && !glitched) begin
        start       = 1'b1;
        cfg_mode    = 1'b1;
        cfg_k_words = 7'd0;
        glitched    = 1'b1;
        glitch_chk  = 2;
      end
      @(negedge clk);
      if (bus.s_ready && bus.s_valid) begin
        e.mode = mode;
        e.a    = mode ? n / kw : n / N_WIN;
        e.b    = mode ? n % kw : n % N_WIN;
        e.d    = bus.s_data;
        sb_q.push_back(e);
        n++;
      end
      @(posedge clk); #1;
      cons_done = 1'b0;
      start     = 1'b0;
      cfg_mode  = mode;
      cyc++;
    end
    bus.s_valid = 1'b0;
    check(n == stop_at, "stream_words", n, stop_at);
  endtask

  // Called one delta after the edge that took the last word (cycle T+1 starts).
  task automatic finish_fill();
    @(negedge clk);
    check(!bus.s_ready && !swap && busy, "drain_cycle", {bus.s_ready, swap, busy}, 1);
    if (tb_credit) begin
      swap_ok = 1'b1;
      @(negedge clk);
      check(swap && fill_done && busy, "swap_after_drain", {swap, fill_done, busy}, 7);
      tb_credit = 1'b0;
      @(posedge clk); #1;
      swap_ok = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check(!swap && busy && !bus.s_ready, "swap_wait_hold", {swap, busy, bus.s_ready}, 2);
      end
      @(posedge clk); #1;
      cons_done = 1'b1;
      tb_credit = 1'b1;
      swap_ok   = 1'b1;
      @(posedge clk); #1;
      cons_done = 1'b0;
      @(negedge clk);
      check(swap && fill_done, "swap_after_release", {swap, fill_done}, 3);
      tb_credit = 1'b0;
      @(posedge clk); #1;
      swap_ok = 1'b0;
    end
    @(negedge clk);
    check(!busy && !swap, "idle_after_swap", {busy, swap}, 0);
    check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic run_fill(input vec_t v);
    @(posedge clk); #1;
    start       = 1'b1;
    cfg_mode    = v.mode;
    cfg_k_words = 7'(v.kw);
    @(posedge clk); #1;
    start = 1'b0;
    if (v.exp_err) begin
      @(negedge clk);
      check(cfg_err && !busy && !bus.s_ready, "cfg_err_pulse", {cfg_err, busy, bus.s_ready}, 4);
      @(negedge clk);
      check(!cfg_err && !busy && !bus.s_ready, "cfg_err_single", {cfg_err, busy, bus.s_ready}, 0);
    end else begin
      stream(v.mode, v.kw, v.exp_words, v.pct, v.cons_at, -1);
      finish_fill();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    cfg_mode    = 1'b0;
    cfg_k_words = 7'd0;
    cons_done   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    tb_credit   = 1'b1;
    swap_ok     = 1'b0;
    glitch_chk  = 0;

    //          mode  kw  pct cons err words
    vecs[0] = '{1'b0,  0, 100, -1, 1'b0,  84};
    vecs[1] = '{1'b0,  0,  50, 10, 1'b0,  84};
    vecs[2] = '{1'b1, 96, 100, -1, 1'b0, 672};
    vecs[3] = '{1'b1,  0, 100, -1, 1'b1,   0};
    vecs[4] = '{1'b1, 97, 100, -1, 1'b1,   0};
    vecs[5] = '{1'b1,  3,  70,  5, 1'b0,  21};
    vecs[6] = '{1'b0, 97,  50, -1, 1'b0,  84};
    vecs[7] = '{1'b1,  1, 100,  0, 1'b0,   7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check({bus.conv_load_en, bus.mlp_load_en, swap, fill_done, busy, cfg_err, bus.s_ready} == 7'd0,
          "reset_outputs", {bus.conv_load_en, bus.mlp_load_en, swap, fill_done, busy, cfg_err, bus.s_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(!busy && !bus.s_ready, "idle_after_reset", {busy, bus.s_ready}, 0);

    for (int i = 0; i < 8; i++) run_fill(vecs[i]);

    // Reset in the middle of a conv fill, with a stray start inside FILL.
    @(posedge clk); #1;
    start    = 1'b1;
    cfg_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    stream(1'b0, 0, 40, 100, -1, 5);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check({bus.conv_load_en, bus.mlp_load_en, bus.conv_load_pe_idx, bus.conv_load_win_idx,
           bus.conv_load_data, swap, fill_done, busy, bus.s_ready, cfg_err} == '0,
          "reset_mid_fill", {busy, swap, bus.conv_load_en, bus.s_ready}, 0);
    check(sb_q.size() == 0, "reset_scoreboard", sb_q.size(), 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    tb_credit = 1'b1;
    run_fill(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_buf_loader.md
Name: input_buf_loader

Overview:
- Write-side sequencer for the double-buffered PE-array input buffer.
- Accepts a 32-bit word stream (valid/ready) and generates write strobes, indices and data for the shadow bank.
- Conv mode writes the per-PE/per-window tap layout; MLP mode writes the row/k-word layout.
- Once the bank is filled and the consumer has released the active bank, issues a single-cycle swap.

Parameters:
- N_ROWS, 7, MLP rows per bank
- K_MAX, 384, bytes per MLP row
- N_PE, 12, PEs per conv bank
- N_WIN, 7, windows per PE
- N_TAP, 4, bytes per 32-bit word

Ports:
- clk  in  1  clock, single domain
- rst  in  1  synchronous reset, active-high
- start  in  1  begin one bank fill; sampled only in IDLE
- cfg_mode  in  1  0=conv, 1=MLP; sampled with start
- cfg_k_words  in  7  MLP words per row, legal 1..K_MAX/N_TAP (96); sampled with start
- s_valid  in  1  stream word valid
- s_data  in  32  stream word, byte0 in [7:0]
- s_ready  out  1  loader accepts word
- cons_done  in  1  consumer finished with active bank (pulse)
- conv_load_en  out  1  conv write strobe
- conv_load_pe_idx  out  4  conv PE index
- conv_load_win_idx  out  3  conv window index
- conv_load_data  out  32  conv write data
- mlp_load_en  out  1  MLP write strobe
- mlp_load_row  out  3  MLP row
- mlp_load_k_word  out  7  MLP word within row
- mlp_load_data  out  32  MLP write data
- swap  out  1  bank swap pulse
- fill_done  out  1  pulse, coincident with swap
- busy  out  1  high outside IDLE
- cfg_err  out  1  pulse on illegal start config

Behaviour:
- Reset: all outputs 0; state IDLE; word counters 0; credit=1 (the empty active bank needs no release).
- States: IDLE, FILL, DRAIN, SWAP_WAIT.
- IDLE:
  - start with legal config: latch mode and k_words, go to FILL.
  - MLP start with k_words==0 or >96: cfg_err high 1 cycle, stay IDLE.
  - Conv start ignores cfg_k_words.
- FILL: s_ready=1. A transfer is s_valid&&s_ready.
- Write timing: each transfer registers exactly one write, seen on the outputs the next cycle (latency 1).
  - Only the enable for the latched mode asserts.
  - Data passes through unmodified.
  - Enables are low on non-transfer cycles; index/data outputs are don't-care then.
- Conv order: win inner (0..N_WIN-1), pe outer (0..N_PE-1); 84 words total.
- MLP order: k_word inner (0..k_words-1), row outer (0..N_ROWS-1); 7*k_words words.
- Unwritten MLP bytes are not cleared.
- Last-word transfer: go to DRAIN, s_ready=0 from the next cycle.
- DRAIN: lasts 1 cycle, while the final write is on the outputs.
  - credit=1: swap and fill_done high the next cycle.
  - credit=0: go to SWAP_WAIT.
- SWAP_WAIT: holds until credit=1, then swap next cycle. No strobes in this state.
- After swap, return to IDLE; start is accepted the following cycle.
- swap is never coincident with a load enable.
- Credit:
  - Set by cons_done in any state; repeated cons_done is idempotent.
  - Cleared in the swap cycle.
  - cons_done coincident with swap is discarded (bench asserts this never happens).
- start outside IDLE: ignored, no error.
- busy = (state != IDLE).
- Reset mid-fill: state and counters cleared, no swap emitted, credit=1. Partial shadow contents are abandoned.

Decomposition:
- Package inbuf_pkg:
  - N_ROWS, K_MAX, N_PE, N_WIN, N_TAP
  - CONV_WORDS=N_PE*N_WIN, MLP_KW_MAX=K_MAX/N_TAP
  - loader state enum
  - shared with the buffer and consumer sequencer
- Sub-module inbuf_addr_gen: two-level inner/outer wrap counter.
  - Inputs: clear, inc, inner limit, outer limit.
  - Outputs: inner, outer, last.
  - One instance, limits muxed by mode.

Test Plan:
- Conv fill, s_valid held high, data=i: load_en on 84 consecutive cycles. Word 7 maps to pe=1/win=0; word 83 to pe=11/win=6. Last handshake at T: strobe at T+1, swap and fill_done at T+2, busy low at T+3.
- Backpressure: s_valid random 50% → exactly 84 strobes, indices contiguous with no skips, data order preserved.
- MLP k_words=96 → 672 strobes, last row=6/k_word=95. MLP k_words=3 → 21 strobes, row increments after k_word=2.
- Credit hold: second fill with no cons_done → SWAP_WAIT, swap held, busy=1. cons_done at cycle C → swap at C+1. cons_done during FILL → swap immediately after DRAIN.
- Config error: MLP start with k_words=0, then 97 → cfg_err pulses each time, no s_ready, state IDLE. start during FILL ignored.
- Reset at word 40 of a conv fill → all outputs 0 the next cycle, no swap. Fresh start begins at pe=0/win=0 and swaps without needing cons_done.
